rv32m_iter_unit: RTL

Iterative RV32M multiply/divide execution unit: the responder side of the `rv32m` request/result interface driven by the RV32M bench and, later, the core's execute stage. It accepts one operation per `in_valid` pulse and computes all eight RV32M functions with a shared 32-step shift/add–subtract datapath. It returns `rd` with a one-cycle `out_valid` pulse after a fixed latency.

---
 rtl/rv32m_pkg.sv | 31 +++
 rtl/rv32m_divstep.sv | 27 ++
 rtl/rv32m_iter_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, funct3 encodings, FSM states and operand-signedness helpers.
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } rv32m_state_t;

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv32m_divstep.sv
// One restoring-division step on a {remainder, quotient} register: shift left
// by one, then subtract the divisor from the upper half if it fits.
module rv32m_divstep
  import rv32m_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2*W-1:0] i_work,
  input  logic [W-1:0]   i_divisor,
  output logic [2*W-1:0] o_work
);

  logic [W:0] w_trial;
  logic [W:0] w_diff;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    w_trial = i_work[2*W-1:W-1];
    w_diff  = w_trial - {1'b0, i_divisor};
    if (w_diff[W]) begin
      o_work = {i_work[2*W-2:0], 1'b0};
    end else begin
      o_work = {w_diff[W-1:0], i_work[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/rv32m_iter_unit.sv
// Iterative RV32M multiply/divide unit: one operation per 35 cycles through a
// shared 32-step shift/add and restoring-divide datapath.
module rv32m_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rd,
  output logic            out_valid,
  output logic            in_error,
  output logic            busy
);
  import rv32m_pkg::*;

  rv32m_state_t      r_state;
  logic [4:0]        r_cnt;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_work;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic              r_ovf;
  logic [XLEN-1:0]   r_rd;
  logic              r_out_valid;
  logic              r_in_error;

  logic              w_is_div;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  assign w_is_div = r_f3[2];
  assign w_sa     = is_signed_a(r_f3) & r_a[XLEN-1];
  assign w_sb     = is_signed_b(r_f3) & r_b[XLEN-1];
  assign w_mag_a  = w_sa ? -r_a : r_a;
  assign w_mag_b  = w_sb ? -r_b : r_b;

  // Multiply: r_work = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_sum      = {1'b0, r_work[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
  assign w_mul_next = r_work[0] ? {w_sum, r_work[XLEN-1:1]} : {1'b0, r_work[2*XLEN-1:1]};

  rv32m_divstep #(.W(XLEN)) u_divstep (
    .i_work    (r_work),
    .i_divisor (r_opnd),
    .o_work    (w_div_next)
  );

  assign w_prod = r_neg_q ? -r_work : r_work;
  assign w_quot = r_neg_q ? -r_work[XLEN-1:0] : r_work[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_work[2*XLEN-1:XLEN] : r_work[2*XLEN-1:XLEN];

  always_comb begin
    w_result = w_prod[XLEN-1:0];
    case (r_f3)
      F3_MUL:                      w_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (r_dz)       w_result = '1;
        else if (r_ovf) w_result = MIN_INT;
        else            w_result = w_quot;
      end
      default: begin
        if (r_dz)       w_result = r_a;
        else if (r_ovf) w_result = '0;
        else            w_result = w_rem;
      end
    endcase
  end

  // Control and outputs: synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_in_error  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_in_error  <= 1'b0;
      case (r_state)
        ST_IDLE: if (in_valid) r_state <= ST_PREP;
        ST_PREP: begin
          r_cnt   <= 5'd31;
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          if (r_cnt == 5'd0) r_state <= ST_FIX;
          else               r_cnt   <= r_cnt - 5'd1;
        end
        ST_FIX: begin
          r_rd        <= w_result;
          r_out_valid <= 1'b1;
          r_in_error  <= r_dz;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are not reset; they are always reloaded before use and never observed otherwise.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          r_a  <= rs1;
          r_b  <= rs2;
          r_f3 <= funct3;
        end
      end
      ST_PREP: begin
        r_work  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_dz    <= w_is_div & (r_b == '0);
        r_ovf   <= w_is_div & ~r_f3[0] & (r_a == MIN_INT) & (r_b == '1);
      end
      ST_CALC: r_work <= w_is_div ? w_div_next : w_mul_next;
      default: ;
    endcase
  end

  assign rd        = r_rd;
  assign out_valid = r_out_valid;
  assign in_error  = r_in_error;
  assign busy      = (r_state != ST_IDLE);

endmodule
